// File: rtl/clk_div_pkg.sv
// Shared constants and state encoding for the programmable clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int DEF_DIV_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t STOP  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;

endpackage

// File: rtl/clk_div_negret.sv
// Negative-edge retiming flop: delays the posedge phase by half a source cycle.
module clk_div_negret (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50% duty integer clock divider; new ratios take effect
// only at an output period boundary so clk_out never produces a runt pulse.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             clk_out,
  output logic             period_tick
);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] half_div;
  logic [CNT_W-1:0] pend_div;
  logic             pend;
  logic             pend_d;
  logic             odd_q;
  logic             clk_p;
  logic             clk_n;
  logic             running;
  logic             at_end;
  logic             start;
  logic             apply;
  logic             hs;
  logic             hs_ok;
  logic             hs_bad;

  assign running  = (state != STOP);
  assign at_end   = running && (cnt == cur_div - CNT_W'(1));
  assign start    = enable && (!running || at_end);
  assign apply    = pend && (!running || at_end);
  assign cnt_inc  = cnt + CNT_W'(1);
  assign half_div = (cur_div >> 1) + CNT_W'(cur_div[0]);

  assign hs     = div_valid && div_ready;
  assign hs_ok  = hs && (div_val >= CNT_W'(2));
  assign hs_bad = hs && (div_val <  CNT_W'(2));

  // Ready cannot be high while a ratio is pending, so apply and accept never coincide.
  assign pend_d = apply ? 1'b0 : (hs_ok ? 1'b1 : pend);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state;
    if (!running || at_end) state_d = enable ? RUN : STOP;
    else                    state_d = enable ? RUN : DRAIN;
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= STOP;
      cnt         <= '0;
      clk_p       <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state       <= state_d;
      period_tick <= start;
      if (start) begin
        cnt   <= '0;
        clk_p <= 1'b1;
      end else if (running && !at_end) begin
        cnt   <= cnt_inc;
        clk_p <= (cnt_inc < half_div);
      end else begin
        cnt   <= '0;
        clk_p <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_div   <= CNT_W'(DEF_DIV);
      odd_q     <= ((DEF_DIV % 2) != 0);
      pend      <= 1'b0;
      pend_div  <= '0;
      div_ready <= 1'b0;
      div_err   <= 1'b0;
    end else begin
      pend      <= pend_d;
      div_ready <= !pend_d;
      div_err   <= hs_bad;
      if (apply) begin
        cur_div <= pend_div;
        odd_q   <= pend_div[0];
      end
      if (hs_ok) pend_div <= div_val;
    end
  end

  clk_div_negret u_negret (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (clk_p),
    .q     (clk_n)
  );

  // Odd ratios use the half-cycle-late copy to trim the high phase to N/2 cycles.
  assign clk_out = clk_p & (clk_n | ~odd_q);

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench: stimulus predicts each output period, a monitor measures them.
module tb_clk_div_prog;

  localparam int W = 8;

  typedef struct {
    int n;
    int at;
  } period_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         div_valid = 1'b0;
  logic [W-1:0] div_val = '0;
  logic         div_ready;
  logic         div_err;
  logic [W-1:0] cur_div;
  logic         clk_out;
  logic         period_tick;

  int      n_tests = 0;
  int      n_fail  = 0;
  int      cyc     = 0;
  int      m_div   = 4;
  bit      mon_on  = 1'b0;
  period_t exp_q[$];

  clk_div_prog #(.CNT_W(W), .DEF_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .div_val     (div_val),
    .div_valid   (div_valid),
    .div_ready   (div_ready),
    .div_err     (div_err),
    .cur_div     (cur_div),
    .clk_out     (clk_out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: on every tick, pop the predicted period and measure it in half-cycles.
  initial begin
    period_t e;
    int      highs;
    int      extra;
    forever begin
      @(posedge clk); #1;
      if (mon_on) begin
        if (period_tick === 1'b1) begin
          check("tick_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tick_edge", cyc, e.at);
            check("cur_div", cur_div, e.n);
            highs = 0;
            extra = 0;
            for (int i = 0; i < e.n; i++) begin
              if (i > 0) begin
                @(posedge clk); #1;
                if (period_tick === 1'b1) extra++;
              end
              if (clk_out === 1'b1) highs++;
              @(negedge clk); #1;
              if (clk_out === 1'b1) highs++;
            end
            check("high_halves", highs, e.n);
            check("tick_gap", extra, 0);
          end
        end else begin
          check("idle_low", clk_out, 0);
        end
      end
    end
  end

  // Enable for e edges; optionally offer new_n at relative edge load_at.
  // Periods start every N edges while enable is sampled high at a boundary;
  // a ratio loaded at edge h takes effect at the first boundary after h.
  task automatic run(input int e, input int load_at, input int new_n);
    int s;
    int nd;
    int base;
    bit applied;
    base    = cyc + 1;
    nd      = m_div;
    s       = 0;
    applied = (load_at < 0);
    while (s < e) begin
      if (!applied && s > load_at) begin
        nd      = new_n;
        applied = 1'b1;
      end
      exp_q.push_back('{n: nd, at: base + s});
      s += nd;
    end
    if (!applied) nd = new_n;
    m_div = nd;
    for (int i = 0; i <= s + 2; i++) begin
      enable    = (i < e);
      div_valid = (i == load_at);
      div_val   = W'(new_n);
      @(posedge clk); #1;
      if (i == load_at) check("ready_low_pending", div_ready, 0);
    end
    div_valid = 1'b0;
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    check("cur_div_after_run", cur_div, m_div);
    check("ready_after_run", div_ready, 1);
  endtask

  task automatic offer_bad(input int v);
    div_valid = 1'b1;
    div_val   = W'(v);
    @(posedge clk); #1;
    div_valid = 1'b0;
    check("err_pulse", div_err, 1);
    check("ready_kept", div_ready, 1);
    check("cur_div_kept", cur_div, m_div);
    @(posedge clk); #1;
    check("err_clear", div_err, 0);
  endtask

  task automatic load_stop(input int n);
    div_valid = 1'b1;
    div_val   = W'(n);
    @(posedge clk); #1;
    div_valid = 1'b0;
    check("stop_ready_low", div_ready, 0);
    check("stop_not_yet", cur_div, m_div);
    @(posedge clk); #1;
    m_div = n;
    check("stop_applied", cur_div, m_div);
    check("stop_ready_back", div_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int r;
    #12;
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", period_tick, 0);
    check("rst_err", div_err, 0);
    check("rst_ready", div_ready, 0);
    check("rst_cur_div", cur_div, 4);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", div_ready, 1);
    mon_on = 1'b1;

    run(12, -1, 0);
    run(20, 5, 7);
    offer_bad(1);
    offer_bad(0);
    load_stop(6);
    run(3, -1, 0);
    load_stop(3);
    run(9, -1, 0);

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) load_stop(int'($urandom_range(2, 13)));
      e = int'($urandom_range(1, 40));
      if ($urandom_range(0, 1) == 1) run(e, -1, 0);
      else run(e, int'($urandom_range(0, e - 1)), int'($urandom_range(2, 13)));
      r = int'($urandom_range(0, 3));
      repeat (r) begin
        @(posedge clk); #1;
      end
    end

    // Reset in the high phase of an odd period with a ratio pending.
    mon_on = 1'b0;
    load_stop(5);
    div_valid = 1'b1;
    div_val   = W'(9);
    enable    = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    check("start_tick", period_tick, 1);
    @(posedge clk); #1;
    check("pre_reset_high", clk_out, 1);
    check("pend_ready_low", div_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", clk_out, 0);
    check("async_cur_div", cur_div, 4);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("cur_div_default", cur_div, 4);
    check("ready_after_reset", div_ready, 1);
    m_div  = 4;
    mon_on = 1'b1;
    run(10, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
